// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM state encoding, latched
// operation encoding, default geometry/timing and the request decode helper.
package mem_pkg;

   localparam int unsigned DEF_ADDR_BITS = 10;
   localparam int unsigned DEF_LATENCY   = 2;
   localparam int unsigned CNT_BITS      = 4;   // LATENCY is limited to 1..15

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_RD   = 2'd1,
      OP_WR   = 2'd2,
      OP_SWAP = 2'd3
   } op_t;

   // Read+write is a swap only when qualified as atomic; otherwise the write
   // wins. The atomic qualifier on a single op has no effect.
   function automatic op_t decode_op(input logic rd, input logic wr, input logic at);
      op_t op;
      op = OP_NONE;
      if (rd && wr)
         op = at ? OP_SWAP : OP_WR;
      else if (wr)
         op = OP_WR;
      else if (rd)
         op = OP_RD;
      return op;
   endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word storage, 2^ADDR_BITS x 32.
//   clk    : clock, rising edge
//   we     : write enable (synchronous write)
//   addr   : word index
//   wdata  : write data
//   rdata  : combinational read of mem[addr]
// Contents are deliberately not reset.
module mem_array #(
   parameter int unsigned ADDR_BITS = 10
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata
);

   logic [31:0] mem [2**ADDR_BITS];

   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder for a cache-side request/wait handshake.
//   clk, rst              : clock (rising edge), async active-high reset
//   ram_addr, ram_data_w  : word address and write data
//   ram_read, ram_write   : request strobes, held while ram_wait is high
//   ram_atomic            : turns read+write into an atomic swap
//   ram_wait              : busy; falls in the cycle the result is valid
//   ram_data_r            : registered read result, valid when ram_wait falls
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting; a request raises ram_wait combinationally and is latched
// BUSY  | counting down latency; inputs ignored, access at counter==0
// DONE  | result on ram_data_r for one cycle; any held request is ignored
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
   parameter int unsigned LATENCY   = DEF_LATENCY
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ram_addr,
   input  logic [31:0] ram_data_w,
   input  logic        ram_read,
   input  logic        ram_write,
   input  logic        ram_atomic,
   output logic        ram_wait,
   output logic [31:0] ram_data_r
);

   localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);

   state_t                state_q, state_d;
   op_t                   op_q, op_d;
   logic [CNT_BITS-1:0]   cnt_q, cnt_d;
   logic [ADDR_BITS-1:0]  addr_q, addr_d;
   logic                  in_range_q, in_range_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           rdata_q, rdata_d;

   logic                  req;
   logic                  access;
   logic                  mem_we;
   logic [31:0]           mem_rdata;

   assign req    = ram_read | ram_write;
   assign access = (state_q == ST_BUSY) && (cnt_q == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_NONE;
         cnt_q      <= '0;
         addr_q     <= '0;
         in_range_q <= 1'b0;
         wdata_q    <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         in_range_q <= in_range_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      in_range_d = in_range_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      ram_wait   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               ram_wait   = 1'b1;
               op_d       = decode_op(ram_read, ram_write, ram_atomic);
               addr_d     = ram_addr[ADDR_BITS-1:0];
               in_range_d = (ram_addr[31:ADDR_BITS] == '0);
               wdata_d    = ram_data_w;
               cnt_d      = CNT_LOAD;
               state_d    = ST_BUSY;
            end
         end
         ST_BUSY: begin
            ram_wait = 1'b1;
            if (cnt_q == '0) begin
               // Swap returns the pre-write contents; the array write lands
               // on this same edge.
               if (in_range_q && (op_q == OP_RD || op_q == OP_SWAP))
                  rdata_d = mem_rdata;
               else
                  rdata_d = '0;
               op_d    = OP_NONE;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Reset holds ram_wait low even though the request inputs may be live.
      if (rst)
         ram_wait = 1'b0;
   end

   assign mem_we = access && in_range_q && (op_q == OP_WR || op_q == OP_SWAP);

   mem_array #(
      .ADDR_BITS(ADDR_BITS)
   ) u_mem_array (
      .clk   (clk),
      .we    (mem_we),
      .addr  (addr_q),
      .wdata (wdata_q),
      .rdata (mem_rdata)
   );

   assign ram_data_r = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ram_addr;
   logic [31:0] ram_data_w;
   logic        ram_read;
   logic        ram_write;
   logic        ram_atomic;
   logic        ram_wait;
   logic [31:0] ram_data_r;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_responder #(
      .ADDR_BITS(10),
      .LATENCY  (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ram_addr   (ram_addr),
      .ram_data_w (ram_data_w),
      .ram_read   (ram_read),
      .ram_write  (ram_write),
      .ram_atomic (ram_atomic),
      .ram_wait   (ram_wait),
      .ram_data_r (ram_data_r)
   );

   // Drives one request from an IDLE cycle, counts ram_wait-high cycles,
   // then checks the wait count and ram_data_r in DONE and drops the request.
   task automatic run_txn(input string name, input logic rd, input logic wr,
                          input logic at, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp);
      int waits = 0;
      bit done  = 0;
      @(negedge clk);
      ram_read = rd; ram_write = wr; ram_atomic = at;
      ram_addr = addr; ram_data_w = wdata;
      for (int c = 0; c < 20 && !done; c++) begin
         #1;
         if (ram_wait) begin
            waits++;
            @(negedge clk);
         end else begin
            done = 1;
         end
      end
      n_cmp++;
      if (!done || waits !== 3) begin
         n_bad++;
         $display("FAIL %s wait_cycles: got %0d expected 3 (done=%0d)", name, waits, done);
      end
      n_cmp++;
      if (ram_data_r !== exp) begin
         n_bad++;
         $display("FAIL %s data_r: got %h expected %h", name, ram_data_r, exp);
      end
      ram_read = 0; ram_write = 0; ram_atomic = 0;
   endtask

   task automatic test_reset();
      rst = 1; ram_read = 1; ram_write = 0; ram_atomic = 0;
      ram_addr = 39; ram_data_w = 0;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if (ram_wait !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_wait: got %b expected 0", ram_wait);
      end
      n_cmp++;
      if (ram_data_r !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_data_r: got %h expected 0", ram_data_r);
      end
      // Request held through reset release is taken as a fresh IDLE request
      @(negedge clk);
      rst = 0;
      #1;
      n_cmp++;
      if (ram_wait !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_release_accept: got %b expected 1", ram_wait);
      end
      // let it complete: two more wait cycles then DONE
      repeat (3) @(negedge clk);
      ram_read = 0;
   endtask

   task automatic test_write_read();
      run_txn("wr39", 0, 1, 0, 39, 1115, 0);
      run_txn("rd39", 1, 0, 0, 39, 0, 1115);
   endtask

   task automatic test_swap();
      run_txn("wr40", 0, 1, 0, 40, 5, 0);
      run_txn("swap40", 1, 1, 1, 40, 9, 5);
      run_txn("rd40", 1, 0, 0, 40, 0, 9);
      run_txn("rw_noatomic41", 1, 1, 0, 41, 33, 0);
      run_txn("rd41", 1, 0, 1, 41, 0, 33);
   endtask

   task automatic test_out_of_range();
      run_txn("wr0", 0, 1, 0, 0, 0, 0);
      run_txn("wr400", 0, 1, 0, 32'h0000_0400, 32'hDEAD, 0);
      run_txn("rd400", 1, 0, 0, 32'h0000_0400, 0, 0);
      run_txn("rd0", 1, 0, 0, 0, 0, 0);
      run_txn("swap_oor", 1, 1, 1, 32'h8000_0027, 7, 0);
      run_txn("rd39_after_oor", 1, 0, 0, 39, 0, 1115);
   endtask

   task automatic test_back_to_back();
      logic exp_pat [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
      run_txn("wr70", 0, 1, 0, 70, 32'h70, 0);
      @(negedge clk);
      ram_read = 1; ram_addr = 70;
      for (int c = 0; c < 8; c++) begin
         #1;
         n_cmp++;
         if (ram_wait !== exp_pat[c]) begin
            n_bad++;
            $display("FAIL held_wait[%0d]: got %b expected %b", c, ram_wait, exp_pat[c]);
         end
         if (c == 7) begin
            n_cmp++;
            if (ram_data_r !== 32'h70) begin
               n_bad++;
               $display("FAIL held_data_r: got %h expected 70", ram_data_r);
            end
         end
         if (c < 7) @(negedge clk);
      end
      ram_read = 0;
   endtask

   task automatic test_reset_mid_busy();
      run_txn("wr71", 0, 1, 0, 71, 32'hAAAA, 0);
      @(negedge clk);
      ram_write = 1; ram_addr = 71; ram_data_w = 77;
      @(negedge clk);          // second wait cycle
      rst = 1;
      #1;
      n_cmp++;
      if (ram_wait !== 1'b0) begin
         n_bad++;
         $display("FAIL midrst_wait: got %b expected 0", ram_wait);
      end
      n_cmp++;
      if (ram_data_r !== 32'h0) begin
         n_bad++;
         $display("FAIL midrst_data_r: got %h expected 0", ram_data_r);
      end
      @(negedge clk);
      ram_write = 0;
      @(negedge clk);
      rst = 0;
      run_txn("rd71_after_rst", 1, 0, 0, 71, 0, 32'hAAAA);
   endtask

   task automatic test_input_change_busy();
      int waits = 0;
      bit done  = 0;
      run_txn("wr72", 0, 1, 0, 72, 32'h72, 0);
      @(negedge clk);
      ram_read = 1; ram_addr = 39;
      for (int c = 0; c < 20 && !done; c++) begin
         #1;
         if (ram_wait) begin
            waits++;
            @(negedge clk);
            if (waits == 1) begin
               ram_addr = 72; ram_write = 1; ram_data_w = 32'hBAD;
            end
         end else begin
            done = 1;
         end
      end
      n_cmp++;
      if (!done || waits !== 3) begin
         n_bad++;
         $display("FAIL chg_wait_cycles: got %0d expected 3", waits);
      end
      n_cmp++;
      if (ram_data_r !== 32'd1115) begin
         n_bad++;
         $display("FAIL chg_data_r: got %h expected %h", ram_data_r, 32'd1115);
      end
      ram_read = 0; ram_write = 0;
      run_txn("rd72", 1, 0, 0, 72, 0, 32'h72);
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_swap();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid_busy();
      test_input_change_busy();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL take parameters, one per line:
  ADDR_BITS, 10, word-index width; storage depth is 2^ADDR_BITS 32-bit words.
  LATENCY, 2, wait cycles before access; legal range 1..15.
REQ-002 The block SHALL have the following ports, one per line (clock and reset first):
  clk  in  1  single clock, rising edge.
  rst  in  1  reset; asynchronous, active-high.
  ram_addr  in  32  word address from the cache.
  ram_data_w  in  32  write data.
  ram_read  in  1  read request.
  ram_write  in  1  write request.
  ram_atomic  in  1  atomic qualifier.
  ram_wait  out  1  busy; the requester holds its request while this is high.
  ram_data_r  out  32  read data; valid when ram_wait falls.

Function
REQ-003 The block SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-004 A request is defined as ram_read|ram_write.
REQ-005 In IDLE with a request, ram_wait SHALL be 1 combinationally in that same cycle.
REQ-006 At the IDLE edge with a request, the block SHALL latch op, addr and data, load counter = LATENCY-1, and go to BUSY.
REQ-007 In BUSY, ram_wait SHALL be 1; the counter SHALL decrement each edge.
REQ-008 At the BUSY edge with counter==0, the block SHALL perform the access and go to DONE.
REQ-009 Total ram_wait-high cycles per transaction SHALL be exactly LATENCY+1.
REQ-010 In DONE, ram_wait SHALL be 0 and ram_data_r SHALL hold the result for one cycle; DONE SHALL always go to IDLE.
REQ-011 A request still asserted in DONE belongs to the finished transaction and SHALL be ignored.
REQ-012 A request still held in the following IDLE cycle SHALL start a new transaction.
REQ-013 Input changes during BUSY or DONE SHALL be ignored; the latched values are used.
REQ-014 Operation decode SHALL be:
  - read only: ram_data_r = mem[addr].
  - write only: mem[addr] = data_w; ram_data_r = 0.
  - read & write without atomic: write only; ram_data_r = 0.
  - read & write with atomic: swap; ram_data_r = old mem[addr], then mem[addr] = data_w, in the same access edge.
  - atomic with a single op: identical to the plain op.
REQ-015 An address is out of range when ram_addr[31:ADDR_BITS] != 0.
REQ-016 Out-of-range addresses SHALL complete with normal timing, with writes discarded and reads returning 0.
REQ-017 ram_data_r SHALL be registered; outside DONE it SHALL retain its last value.
REQ-018 The storage address SHALL be ram_addr[ADDR_BITS-1:0]; there is no byte addressing and no wrap beyond the range check.

Reset
REQ-019 On rst, the block SHALL immediately set state=IDLE, counter=0, ram_data_r=0 and latched op=none.
REQ-020 During rst, ram_wait SHALL be 0 regardless of the request inputs.
REQ-021 Reset mid-transaction SHALL abort the transaction with no memory write.
REQ-022 Storage contents SHALL NOT be reset.
REQ-023 After rst deasserts, a held request SHALL be accepted as a new IDLE request.

Structure
REQ-024 Shared package mem_pkg SHALL hold:
  - state encoding (IDLE/BUSY/DONE);
  - op encoding (NONE, RD, WR, SWAP);
  - default ADDR_BITS/LATENCY.
REQ-025 A single sub-module mem_array SHALL hold the storage: single-port, synchronous write, combinational read, 2^ADDR_BITS x 32.
REQ-026 The FSM, decode and counter SHALL live in mem_responder.

Verification (LATENCY=2)
REQ-027 Write then read:
  - stimulus: write addr 39, data 1115; after ram_wait falls, drop the request; then read addr 39.
  - response: ram_wait high for 3 cycles each time; ram_data_r=1115 in DONE.
REQ-028 Swap:
  - stimulus: mem[40]=5; request read+write+atomic at addr 40 with data 9.
  - response: ram_data_r=5; a subsequent read of 40 returns 9.
REQ-029 Out of range:
  - stimulus: write 0xDEAD to addr 32'h0000_0400 (ADDR_BITS=10); then read 0x400 and read 0.
  - response: both reads return 0, with normal 3-cycle wait.
REQ-030 Held request:
  - stimulus: keep ram_read high for 8 cycles at addr 70.
  - response: two back-to-back transactions; ram_wait pattern 1,1,1,0,1,1,1,0.
REQ-031 Reset mid-BUSY:
  - stimulus: assert rst on the 2nd wait cycle of a write of 77 to addr 71; then read 71 after reset.
  - response: ram_wait=0 and ram_data_r=0 immediately; mem[71] unchanged.
REQ-032 Input change in BUSY:
  - stimulus: start a read at addr 39; switch ram_addr to 72 and assert ram_write mid-transaction.
  - response: ram_data_r=mem[39]; mem[72] unchanged.
